// File: rtl/oled_spi_sink_pkg.sv
// Shared constants and types for the OLED SPI sink: command opcodes,
// parser state encoding and default panel geometry.
package oled_spi_sink_pkg;

  localparam int DEFAULT_WIDTH  = 96;
  localparam int DEFAULT_HEIGHT = 64;

  localparam logic [7:0] CMD_SET_COL = 8'h15;
  localparam logic [7:0] CMD_SET_ROW = 8'h75;

  typedef enum logic [2:0] {
    IDLE,
    COL_START,
    COL_END,
    ROW_START,
    ROW_END
  } parse_state_e;

endpackage

// File: rtl/oled_spi_sink_if.sv
// Bundle of the SPI pins driven by the display master and the decoded
// command/pixel outputs of the sink.
interface oled_spi_sink_if;

  logic       oled_csn;
  logic       oled_clk;
  logic       oled_mosi;
  logic       oled_dc;
  logic       oled_resn;

  logic       cmd_valid;
  logic [7:0] cmd_byte;
  logic       pix_valid;
  logic [6:0] pix_x;
  logic [5:0] pix_y;
  logic [7:0] pix_color;
  logic       frame_done;

  modport master (
    output oled_csn, oled_clk, oled_mosi, oled_dc, oled_resn,
    input  cmd_valid, cmd_byte, pix_valid, pix_x, pix_y, pix_color, frame_done
  );

  modport slave (
    input  oled_csn, oled_clk, oled_mosi, oled_dc, oled_resn,
    output cmd_valid, cmd_byte, pix_valid, pix_x, pix_y, pix_color, frame_done
  );

endinterface

// File: rtl/oled_spi_sink_spi_byte_rx.sv
// SPI byte receiver: 2-flop synchronizers on all pins, SCK rising-edge
// detect and MSB-first shifter; byte_strobe marks the cycle the 8th bit lands.
module spi_byte_rx (
  input  logic       clk,
  input  logic       resn,
  input  logic       spi_csn,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  input  logic       spi_dc,
  input  logic       spi_resn,
  output logic [7:0] rx_byte,
  output logic       rx_dc,
  output logic       byte_strobe,
  output logic       spi_resn_sync
);

  // Bit order: {resn, dc, mosi, clk, csn}; csn idles high, display reset held until synced.
  localparam logic [4:0] SYNC_RST = 5'b00001;

  logic [4:0] raw_in;
  logic [4:0] sync1_q, sync2_q;
  logic       csn_s, sclk_s, mosi_s, dc_s;

  logic       sclk_prev_q, sclk_prev_d;
  logic [6:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       sclk_rise;

  assign raw_in = {spi_resn, spi_dc, spi_mosi, spi_clk, spi_csn};

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      sync1_q <= SYNC_RST;
      sync2_q <= SYNC_RST;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
    end
  end

  assign csn_s         = sync2_q[0];
  assign sclk_s        = sync2_q[1];
  assign mosi_s        = sync2_q[2];
  assign dc_s          = sync2_q[3];
  assign spi_resn_sync = sync2_q[4];

  assign sclk_rise = sclk_s & ~sclk_prev_q;

  always_comb begin
    sclk_prev_d = sclk_s;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    byte_strobe = 1'b0;
    rx_byte     = {shift_q, mosi_s};
    rx_dc       = dc_s;
    if (!spi_resn_sync || csn_s) begin
      bit_cnt_d = 3'd0;
    end else if (sclk_rise) begin
      shift_d   = {shift_q[5:0], mosi_s};
      bit_cnt_d = bit_cnt_q + 3'd1;
      // Counter wraps to 0 on its own after the 8th bit.
      byte_strobe = (bit_cnt_q == 3'd7);
    end
  end

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      sclk_prev_q <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
    end else begin
      sclk_prev_q <= sclk_prev_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/oled_spi_sink.sv
// OLED SPI sink: decodes column/row window commands and turns data bytes
// into addressed pixel writes. Define OLED_SPI_SINK_FRAME_EN for frame_done.
module oled_spi_sink
  import oled_spi_sink_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int HEIGHT = DEFAULT_HEIGHT
) (
  input  logic            clk,
  input  logic            resn,
  oled_spi_sink_if.slave  bus
);

  localparam logic [6:0] X_MAX = 7'(WIDTH - 1);
  localparam logic [5:0] Y_MAX = 6'(HEIGHT - 1);

  logic [7:0] rx_byte;
  logic       rx_dc;
  logic       byte_strobe;
  logic       oled_resn_s;

  spi_byte_rx u_rx (
    .clk           (clk),
    .resn          (resn),
    .spi_csn       (bus.oled_csn),
    .spi_clk       (bus.oled_clk),
    .spi_mosi      (bus.oled_mosi),
    .spi_dc        (bus.oled_dc),
    .spi_resn      (bus.oled_resn),
    .rx_byte       (rx_byte),
    .rx_dc         (rx_dc),
    .byte_strobe   (byte_strobe),
    .spi_resn_sync (oled_resn_s)
  );

  parse_state_e state_q, state_d;
  logic [6:0]   col_start_q, col_start_d, col_end_q, col_end_d, x_q, x_d;
  logic [5:0]   row_start_q, row_start_d, row_end_q, row_end_d, y_q, y_d;
  logic         cmd_valid_q, cmd_valid_d, pix_valid_q, pix_valid_d;
  logic [7:0]   cmd_byte_q, cmd_byte_d, pix_color_q, pix_color_d;
  logic [6:0]   pix_x_q, pix_x_d;
  logic [5:0]   pix_y_q, pix_y_d;
  logic [6:0]   arg_x;
  logic [5:0]   arg_y;
`ifdef OLED_SPI_SINK_FRAME_EN
  logic         frame_done_q, frame_done_d;
`endif

  assign arg_x = (rx_byte > {1'b0, X_MAX}) ? X_MAX : rx_byte[6:0];
  assign arg_y = (rx_byte > {2'b00, Y_MAX}) ? Y_MAX : rx_byte[5:0];

  always_comb begin
    state_d     = state_q;
    col_start_d = col_start_q;
    col_end_d   = col_end_q;
    row_start_d = row_start_q;
    row_end_d   = row_end_q;
    x_d         = x_q;
    y_d         = y_q;
    cmd_valid_d = 1'b0;
    cmd_byte_d  = cmd_byte_q;
    pix_valid_d = 1'b0;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_color_d = pix_color_q;
`ifdef OLED_SPI_SINK_FRAME_EN
    frame_done_d = 1'b0;
`endif
    if (!oled_resn_s) begin
      state_d     = IDLE;
      col_start_d = '0;
      col_end_d   = X_MAX;
      row_start_d = '0;
      row_end_d   = Y_MAX;
      x_d         = '0;
      y_d         = '0;
      cmd_byte_d  = '0;
      pix_x_d     = '0;
      pix_y_d     = '0;
      pix_color_d = '0;
    end else if (byte_strobe && !rx_dc) begin
      cmd_valid_d = 1'b1;
      cmd_byte_d  = rx_byte;
      case (state_q)
        IDLE: begin
          if (rx_byte == CMD_SET_COL)      state_d = COL_START;
          else if (rx_byte == CMD_SET_ROW) state_d = ROW_START;
        end
        COL_START: begin
          col_start_d = arg_x;
          state_d     = COL_END;
        end
        COL_END: begin
          col_end_d = (arg_x < col_start_q) ? col_start_q : arg_x;
          x_d       = col_start_q;
          state_d   = IDLE;
        end
        ROW_START: begin
          row_start_d = arg_y;
          state_d     = ROW_END;
        end
        ROW_END: begin
          row_end_d = (arg_y < row_start_q) ? row_start_q : arg_y;
          y_d       = row_start_q;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (byte_strobe) begin
      // A pixel aborts any pending argument but keeps already latched values.
      state_d     = IDLE;
      pix_valid_d = 1'b1;
      pix_x_d     = x_q;
      pix_y_d     = y_q;
      pix_color_d = rx_byte;
      if (x_q >= col_end_q) begin
        x_d = col_start_q;
        if (y_q >= row_end_q) begin
          y_d = row_start_q;
`ifdef OLED_SPI_SINK_FRAME_EN
          frame_done_d = 1'b1;
`endif
        end else begin
          y_d = y_q + 6'd1;
        end
      end else begin
        x_d = x_q + 7'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      state_q     <= IDLE;
      col_start_q <= '0;
      col_end_q   <= X_MAX;
      row_start_q <= '0;
      row_end_q   <= Y_MAX;
      x_q         <= '0;
      y_q         <= '0;
      cmd_valid_q <= 1'b0;
      cmd_byte_q  <= '0;
      pix_valid_q <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_color_q <= '0;
    end else begin
      state_q     <= state_d;
      col_start_q <= col_start_d;
      col_end_q   <= col_end_d;
      row_start_q <= row_start_d;
      row_end_q   <= row_end_d;
      x_q         <= x_d;
      y_q         <= y_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_byte_q  <= cmd_byte_d;
      pix_valid_q <= pix_valid_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_color_q <= pix_color_d;
    end
  end

`ifdef OLED_SPI_SINK_FRAME_EN
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) frame_done_q <= 1'b0;
    else       frame_done_q <= frame_done_d;
  end
  assign bus.frame_done = frame_done_q;
`else
  assign bus.frame_done = 1'b0;
`endif

  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_byte  = cmd_byte_q;
  assign bus.pix_valid = pix_valid_q;
  assign bus.pix_x     = pix_x_q;
  assign bus.pix_y     = pix_y_q;
  assign bus.pix_color = pix_color_q;

endmodule
